// File: rtl/bypass_bin_seq.sv
// Bypass-bin sequencer for the CABAC arithmetic decoder.
// A request asks for up to MAX_BINS equiprobable bins. Bits come from a
// 16-bit bit buffer that is fed one byte at a time. The buffer persists
// between requests. The datapath decodes up to two bins per cycle.
//
// Byte handshake: bs_data is transferred on a rising edge where
// bs_valid && bs_ready. bs_ready depends only on the registered bit count
// (count <= 8), so it never depends on bs_valid. This holds in every state.
module bypass_bin_seq #(
  parameter int MAX_BINS = 32,
  parameter int CNT_W    = 6
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [CNT_W-1:0]    num_bins,
  input  logic [8:0]          range_in,
  input  logic [15:0]         value_in,
  input  logic                bs_flush,
  input  logic                bs_valid,
  input  logic [7:0]          bs_data,
  output logic                bs_ready,
  output logic                busy,
  output logic                done,
  output logic [MAX_BINS-1:0] bins_out,
  output logic [15:0]         value_out
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]          state;
  logic [15:0]         bit_buf;    // valid bits left-aligned, next bit at [15]
  logic [4:0]          bit_cnt;    // 0..16 valid bits
  logic                live;       // holds bs_ready low until the first edge after reset
  logic [8:0]          range_q;
  logic [15:0]         value_q;
  logic [CNT_W-1:0]    remaining;
  logic [MAX_BINS-1:0] acc;
  logic [MAX_BINS-1:0] bins_q;
  logic [15:0]         value_out_q;
  logic                done_q;

  // One bypass bin: shift in a bit and compare against range<<7.
  // The value stays below the scaled range, so the result fits in 16 bits.
  function automatic logic [16:0] bin_step(input logic [15:0] v, input logic b,
                                           input logic [15:0] sc);
    logic [16:0] nv;
    nv = {v, b};
    if (nv >= {1'b0, sc}) bin_step = {1'b1, nv[15:0] - sc};
    else                  bin_step = {1'b0, nv[15:0]};
  endfunction

  logic [15:0]         scaled;
  logic [16:0]         step1;
  logic [16:0]         step2;
  logic [1:0]          k;
  logic [1:0]          consumed;
  logic [15:0]         run_value;
  logic [MAX_BINS-1:0] run_acc;
  logic [CNT_W-1:0]    rem_next;
  logic [CNT_W-1:0]    nb_clamped;
  logic                accept;
  logic                flush_now;
  logic [15:0]         base_buf;
  logic [4:0]          base_cnt;
  logic [15:0]         buf_next;
  logic [4:0]          cnt_next;

  assign scaled     = {range_q, 7'd0};
  assign step1      = bin_step(value_q, bit_buf[15], scaled);
  assign step2      = bin_step(step1[15:0], bit_buf[14], scaled);
  assign rem_next   = remaining - CNT_W'(k);
  assign nb_clamped = (num_bins > CNT_W'(MAX_BINS)) ? CNT_W'(MAX_BINS) : num_bins;
  assign bs_ready   = live && (bit_cnt <= 5'd8);
  assign accept     = bs_valid && bs_ready;
  assign flush_now  = (state == S_IDLE) && bs_flush;
  assign consumed   = (state == S_RUN) ? k : 2'd0;
  assign busy       = (state == S_RUN);
  assign done       = done_q;
  assign bins_out   = bins_q;
  assign value_out  = value_out_q;

  // Bins this cycle: k = min(2, remaining, buffered bits); select stage results.
  always_comb begin
    k = 2'd2;
    if (remaining < CNT_W'(2)) k = remaining[1:0];
    if ({3'd0, k} > bit_cnt) k = bit_cnt[1:0];
    run_value = value_q;
    run_acc   = acc;
    case (k)
      2'd2: begin
        run_value = step2[15:0];
        run_acc   = {acc[MAX_BINS-3:0], step1[16], step2[16]};
      end
      2'd1: begin
        run_value = step1[15:0];
        run_acc   = {acc[MAX_BINS-2:0], step1[16]};
      end
      default: ;
    endcase
  end

  // Next bit buffer: drop consumed bits (or flush), then append an accepted byte.
  always_comb begin
    base_buf = flush_now ? 16'd0 : (bit_buf << consumed);
    base_cnt = flush_now ? 5'd0 : (bit_cnt - {3'd0, consumed});
    buf_next = base_buf;
    cnt_next = base_cnt;
    if (accept) begin
      buf_next = base_buf | ({bs_data, 8'h00} >> base_cnt);
      cnt_next = base_cnt + 5'd8;
    end
  end

  // Bit buffer registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_buf <= 16'd0;
      bit_cnt <= 5'd0;
      live    <= 1'b0;
    end else begin
      bit_buf <= buf_next;
      bit_cnt <= cnt_next;
      live    <= 1'b1;
    end
  end

  // Request FSM, bin accumulator and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      range_q     <= 9'd0;
      value_q     <= 16'd0;
      remaining   <= '0;
      acc         <= '0;
      bins_q      <= '0;
      value_out_q <= 16'd0;
      done_q      <= 1'b0;
    end else begin
      done_q <= (state == S_DONE);
      case (state)
        S_IDLE: begin
          if (!bs_flush && start) begin
            range_q   <= range_in;
            value_q   <= value_in;
            remaining <= nb_clamped;
            acc       <= '0;
            if (nb_clamped == '0) begin
              state       <= S_DONE;
              bins_q      <= '0;
              value_out_q <= value_in;
            end else begin
              state <= S_RUN;
            end
          end
        end
        S_RUN: begin
          value_q   <= run_value;
          acc       <= run_acc;
          remaining <= rem_next;
          if (rem_next == '0) begin
            state       <= S_DONE;
            bins_q      <= run_acc;
            value_out_q <= run_value;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bypass_bin_seq.sv
// Bench for bypass_bin_seq: directed requests with hand-computed results,
// randomized traffic, and a queue-based reference model checked every cycle.
module tb_bypass_bin_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        start = 1'b0;
  logic [5:0]  num_bins = 6'd0;
  logic [8:0]  range_in = 9'd256;
  logic [15:0] value_in = 16'd0;
  logic        bs_flush = 1'b0;
  logic        bs_valid = 1'b0;
  logic [7:0]  bs_data = 8'd0;
  logic        bs_ready;
  logic        busy;
  logic        done;
  logic [31:0] bins_out;
  logic [15:0] value_out;

  int n_vec = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  bypass_bin_seq #(.MAX_BINS(32), .CNT_W(6)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .num_bins(num_bins),
    .range_in(range_in), .value_in(value_in), .bs_flush(bs_flush),
    .bs_valid(bs_valid), .bs_data(bs_data), .bs_ready(bs_ready),
    .busy(busy), .done(done), .bins_out(bins_out), .value_out(value_out)
  );

  // Clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: bitstream as a queue of bits, request as plain integers.
  bit          bq[$];
  int          m_phase = 0;  // 0 idle, 1 decoding, 2 finishing
  int          m_rem = 0;
  int          m_was, m_k, m_n;
  logic [15:0] m_value = 0;
  logic [8:0]  m_range = 0;
  logic [31:0] m_acc = 0;
  logic [31:0] m_bins_out = 0;
  logic [15:0] m_value_out = 0;
  bit          m_done = 0;
  bit          m_live = 0;
  bit          m_take;
  logic [16:0] m_st;

  function automatic logic [16:0] mstep(input logic [15:0] v, input bit b, input logic [8:0] r);
    int nv, sc;
    nv = int'(v) * 2 + int'(b);
    sc = int'(r) * 128;
    if (nv >= sc) mstep = {1'b1, 16'(nv - sc)};
    else          mstep = {1'b0, 16'(nv)};
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bq.delete();
      m_phase = 0; m_rem = 0; m_value = 0; m_range = 0; m_acc = 0;
      m_bins_out = 0; m_value_out = 0; m_done = 0; m_live = 0;
    end else begin
      m_was  = m_phase;
      m_take = bs_valid && m_live && (bq.size() <= 8);
      if (m_phase == 0) begin
        if (bs_flush) bq.delete();
        else if (start) begin
          m_n = (int'(num_bins) > 32) ? 32 : int'(num_bins);
          m_range = range_in; m_value = value_in; m_rem = m_n; m_acc = 0;
          if (m_n == 0) begin
            m_phase = 2; m_bins_out = 0; m_value_out = value_in;
          end else m_phase = 1;
        end
      end else if (m_phase == 1) begin
        m_k = 2;
        if (m_rem < m_k) m_k = m_rem;
        if (bq.size() < m_k) m_k = bq.size();
        for (int i = 0; i < m_k; i++) begin
          m_st = mstep(m_value, bq.pop_front(), m_range);
          m_value = m_st[15:0];
          m_acc = {m_acc[30:0], m_st[16]};
        end
        m_rem -= m_k;
        if (m_rem == 0) begin
          m_phase = 2; m_bins_out = m_acc; m_value_out = m_value;
        end
      end else m_phase = 0;
      if (m_take) for (int i = 7; i >= 0; i--) bq.push_back(bs_data[i]);
      m_done = (m_was == 2);
      m_live = 1;
    end
  end

  // Scoreboard compare every cycle, away from the rising edge.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("busy", 32'(busy), 32'(m_phase == 1));
      chk("done", 32'(done), 32'(m_done));
      chk("bs_ready", 32'(bs_ready), 32'(m_live && (bq.size() <= 8)));
      chk("bins_out", bins_out, m_bins_out);
      chk("value_out", 32'(value_out), 32'(m_value_out));
    end
  end

  // Driver: issue a request; optionally present one byte so that it is
  // accepted on edge d after the start edge. Returns edges from start to done.
  task automatic req(input int n, input int rng, input logic [15:0] val,
                     input int d, input logic [7:0] data, input bit give,
                     output int lat);
    start = 1'b1; num_bins = 6'(n); range_in = 9'(rng); value_in = val;
    bs_valid = give && (d == 0); bs_data = data;
    lat = -1;
    for (int p = 0; p < 300; p++) begin
      @(negedge clk);
      start = 1'b0; bs_valid = 1'b0;
      if (done) begin lat = p; break; end
      if (give && d > 0 && p == d - 1) bs_valid = 1'b1;
    end
    @(negedge clk);
  endtask

  task automatic do_flush();
    bs_flush = 1'b1;
    @(negedge clk);
    bs_flush = 1'b0;
    @(negedge clk);
  endtask

  int lat;
  int rng;

  initial begin
    // Reset
    #3 rst_n = 1'b0;
    chk_en = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_bs_ready", 32'(bs_ready), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_bins", bins_out, 32'd0);
    #2 rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Zero value, zero byte: all bins 0.
    req(8, 256, 16'h0000, 0, 8'h00, 1'b1, lat);
    chk("t1_lat", 32'(lat), 32'd5);
    chk("t1_bins", bins_out, 32'h00);
    chk("t1_value", 32'(value_out), 32'h0000);

    // Top value, ones byte: all bins 1, value unchanged.
    req(8, 256, 16'h7FFF, 0, 8'hFF, 1'b1, lat);
    chk("t2_lat", 32'(lat), 32'd5);
    chk("t2_bins", bins_out, 32'hFF);
    chk("t2_value", 32'(value_out), 32'h7FFF);

    // Odd count leaves 5 bits buffered, then consumed with no new byte.
    req(3, 256, 16'h7FFF, 0, 8'h00, 1'b1, lat);
    chk("t3_lat", 32'(lat), 32'd3);
    chk("t3_bins", bins_out, 32'h7);
    chk("t3_value", 32'(value_out), 32'h7FF8);
    req(5, 256, 16'h7FF8, 0, 8'h00, 1'b0, lat);
    chk("t3b_lat", 32'(lat), 32'd4);
    chk("t3b_bins", bins_out, 32'h1F);
    chk("t3b_value", 32'(value_out), 32'h7F00);

    // Flush with 5 stale zero bits: the next request must see the new byte.
    req(3, 256, 16'h7FFF, 0, 8'h00, 1'b1, lat);
    do_flush();
    chk("flush_ready", 32'(bs_ready), 32'd1);
    req(2, 256, 16'h0000, 0, 8'hC0, 1'b1, lat);
    chk("flush_lat", 32'(lat), 32'd2);
    chk("flush_value", 32'(value_out), 32'h0003);
    do_flush();

    // Stall: byte withheld for four edges after start.
    req(3, 256, 16'h7FFF, 4, 8'h00, 1'b1, lat);
    chk("stall_lat", 32'(lat), 32'd7);
    chk("stall_bins", bins_out, 32'h7);
    chk("stall_value", 32'(value_out), 32'h7FF8);
    do_flush();

    // Zero bins.
    req(0, 300, 16'h1234, 0, 8'h00, 1'b0, lat);
    chk("n0_lat", 32'(lat), 32'd1);
    chk("n0_bins", bins_out, 32'h0);
    chk("n0_value", 32'(value_out), 32'h1234);

    // Full 32-bin request, bs_valid always high, start while busy ignored.
    start = 1'b1; num_bins = 6'd32; range_in = 9'd256; value_in = 16'h1357;
    bs_valid = 1'b1; bs_data = 8'h96;
    lat = -1;
    for (int p = 0; p < 300; p++) begin
      @(negedge clk);
      start = (p == 4); num_bins = (p == 4) ? 6'd3 : 6'd32;
      bs_data = 8'($urandom);
      if (done) begin lat = p; break; end
    end
    start = 1'b0; bs_valid = 1'b0;
    chk("n32_lat", 32'(lat), 32'd17);
    @(negedge clk);
    do_flush();

    // Reset in the middle of a run.
    start = 1'b1; num_bins = 6'd20; range_in = 9'd400; value_in = 16'h0100;
    bs_valid = 1'b1; bs_data = 8'h5A;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_ready", 32'(bs_ready), 32'd0);
    chk("mid_rst_done", 32'(done), 32'd0);
    repeat (3) begin
      @(negedge clk);
      chk("mid_rst_no_done", 32'(done), 32'd0);
    end
    bs_valid = 1'b0;
    #2 rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Randomized traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      rng      = $urandom_range(256, 510);
      start    = ($urandom_range(0, 3) == 0);
      num_bins = 6'($urandom_range(0, 40));
      range_in = 9'(rng);
      value_in = 16'($urandom_range(0, rng * 128 - 1));
      bs_flush = ($urandom_range(0, 19) == 0);
      bs_valid = ($urandom_range(0, 3) != 0);
      bs_data  = 8'($urandom);
    end
    start = 1'b0; bs_flush = 1'b0; bs_valid = 1'b0;
    repeat (4) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/bypass_bin_seq.md
Name: bypass_bin_seq

Overview:
Sequencer for the CABAC bypass (equiprobable) bin datapath in the VVC arithmetic decoder. It accepts a request for N bypass bins with the current range/value, feeds bitstream bits from a byte-wide input into a two-stage bin-per-cycle bypass datapath, and decodes up to 2 bins per cycle. It returns the packed bins and the updated value to the context/regular-bin engine.
The bit buffer persists across requests so bitstream continuity is kept between bypass runs.

Parameters:
MAX_BINS, 32, maximum bins per request; width of bins_out
CNT_W, 6, width of num_bins and of the internal remaining-bin counter (must hold MAX_BINS)

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  request strobe; sampled only in IDLE
num_bins  input  CNT_W  bins to decode, 0..MAX_BINS; captured with start
range_in  input  9  current m_range (256..510); captured with start, constant for the run
value_in  input  16  current m_value; captured with start
bs_flush  input  1  clears the bit buffer (slice/tile start); honoured only in IDLE
bs_valid  input  1  bitstream byte valid
bs_data  input  8  bitstream byte, MSB consumed first
bs_ready  output  1  byte accepted when bs_valid && bs_ready
busy  output  1  high while a request is in progress
done  output  1  one-cycle pulse: bins_out/value_out valid
bins_out  output  MAX_BINS  decoded bins, first bin most significant, right-aligned
value_out  output  16  m_value after the last bin

Behaviour:
- Reset (async, rst_n=0):
  - State is IDLE.
  - bit buffer and its count are 0.
  - busy=0, done=0, bins_out=0, value_out=0, bs_ready=0.
- Bit buffer:
  - 16-bit shift register with a count of 0..16.
  - bs_ready = (count <= 8) in any state (registered count).
  - An accepted byte is appended below the remaining valid bits.
  - In the same cycle: new count = count - consumed + 8·accepted.
- Per-bin math, for each bin:
  - scaled = range<<7 (16 bits).
  - nv = {value, next_bit} (17 bits).
  - bin = (nv >= scaled).
  - value = bin ? nv - scaled : nv[15:0].
  - Invariant value < scaled, so the result fits in 16 bits.
  - Stage 2 uses the stage-1 result and the following bit.
- Bins per RUN cycle: k = min(2, remaining, count), computed on registered values.
  - k=0 stalls; value, bins and remaining are held.
- State machine:
  - IDLE:
    - If bs_flush: count=0, and start is ignored that cycle.
    - Else if start: latch range/value/num_bins and clear the bin accumulator. Go to DONE if num_bins=0, else go to RUN.
    - busy=0.
  - RUN:
    - busy=1.
    - Each cycle: value updates, acc = (acc<<k) | bins, remaining -= k.
    - When remaining reaches 0: go to DONE, with bins_out=acc and value_out=value registered.
  - DONE:
    - done=1 for exactly one cycle, busy=0, then IDLE.
    - For num_bins=0: bins_out=0, value_out=value_in.
- Latency:
  - With bits available, done is high ceil(N/2)+1 cycles after the start edge.
  - Each stall cycle adds 1.
- Output hold: bins_out and value_out hold until the next completed request.
- Ignored inputs:
  - start outside IDLE is ignored (no queuing).
  - bs_flush outside IDLE is ignored.
- num_bins > MAX_BINS: clamped to MAX_BINS.
- Reset mid-run: immediate abort. All state, including the bit buffer, clears and no done is issued.

Test Plan:
- value_in=0x0000, range_in=256, N=8, byte 0x00 → done after 5 cycles (4 RUN + DONE edge), bins_out=0x00, value_out=0x0000, count back to 0.
- value_in=0x7FFF, range_in=256, N=8, byte 0xFF → bins_out=0xFF, value_out=0x7FFF.
- value_in=0x7FFF, range_in=256, N=3, byte 0x00 → bins 1,1,1 (bins_out=0x7), value_out=0x7FF8; 5 bits remain buffered.
  - Then N=5 on the remaining bits continues without a new byte.
- Odd count/stall: N=3 with the byte withheld 4 cycles after start → busy stays high, no bins consumed during the stall.
  - Then 2+1 bins; done 4 cycles later than the unstalled case.
- Boundaries:
  - N=0 → done on the next cycle, bins_out=0, value_out=value_in.
  - N=32 across 4 bytes with bs_valid always high → 16 RUN cycles, bs_ready never high with count>8.
  - start while busy → ignored.
- Reset/flush:
  - rst_n low mid-RUN → busy=0, done never pulses, bs_ready=0 during reset.
  - bs_flush in IDLE with 5 bits buffered → count=0, bs_ready=1.
